// File: rtl/axi4_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_burst_ram
//  Purpose  : AXI4 slave scratch memory with FIXED/INCR/WRAP bursts, narrow
//             strobed writes, ID echo, backpressure and SLVERR reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SHIFT      = $clog2(STRB_WIDTH);
    localparam int MEM_WORDS  = MEM_BYTES / STRB_WIDTH;
    localparam int IDX_WIDTH  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0]          MAX_SIZE    = 3'(SHIFT);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT   = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;
    localparam logic [1:0]          BURST_INCR  = 2'b01;
    localparam logic [1:0]          BURST_WRAP  = 2'b10;
    localparam logic [1:0]          BURST_RSVD  = 2'b11;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Address of the beat following a, modulo 2**ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
        input logic [7:0] len, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] sb;
        logic [ADDR_WIDTH-1:0] cont;
        sb   = ADDR_WIDTH'(1) << size;
        cont = sb * ADDR_WIDTH'({1'b0, len} + 9'd1);
        case (burst)
            BURST_INCR: next_addr = (a & ~(sb - ADDR_WIDTH'(1))) + sb;
            BURST_WRAP: next_addr = (a & ~(cont - ADDR_WIDTH'(1)))
                                  | ((a + sb) & (cont - ADDR_WIDTH'(1)));
            default:    next_addr = a;
        endcase
    endfunction

    // Errors that poison every beat of a transaction.
    function automatic logic txn_err(input logic [1:0] burst, input logic [7:0] len,
                                     input logic [2:0] size);
        txn_err = (burst == BURST_RSVD)
               || (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 ||
                                            len == 8'd7 || len == 8'd15))
               || (size > MAX_SIZE);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        in_range = ({1'b0, a} < MEM_LIMIT);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = IDX_WIDTH'(a >> SHIFT);
    endfunction

    // ------------------------------------------------------------------ write
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    wstate_t w_state, w_next;

    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_txn_err, w_err;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_err, w_we;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_last_beat = (w_cnt == w_len);
    // Beat count ends the burst; a wlast disagreeing with it only flags SLVERR.
    assign w_beat_err  = !in_range(w_addr) || (s_axi_wlast != w_last_beat);
    assign w_we        = w_hs && !w_txn_err && in_range(w_addr);

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next-state logic.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write channel registers; readies/valids are registered copies of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
            w_size <= '0; w_burst <= '0; w_txn_err <= 1'b0; w_err <= 1'b0;
        end else begin
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id      <= s_axi_awid;
                w_addr    <= s_axi_awaddr;
                w_len     <= s_axi_awlen;
                w_size    <= s_axi_awsize;
                w_burst   <= s_axi_awburst;
                w_cnt     <= '0;
                w_txn_err <= txn_err(s_axi_awburst, s_axi_awlen, s_axi_awsize);
                w_err     <= txn_err(s_axi_awburst, s_axi_awlen, s_axi_awsize);
            end
            if (w_hs) begin
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                w_err  <= w_err | w_beat_err;
                if (w_last_beat) begin
                    s_axi_bid   <= w_id;
                    s_axi_bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Byte-strobed memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;
    rstate_t r_state, r_next;

    logic [ADDR_WIDTH-1:0] rd_addr, ld_addr;
    logic [7:0]            rd_len, rd_cnt, ld_len, ld_cnt;
    logic [2:0]            rd_size, ld_size;
    logic [1:0]            rd_burst, ld_burst;
    logic                  rd_txn_err, ld_terr, ld_ok;
    logic                  ar_hs, r_hs, load;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    // First beat loads on the AR handshake; later beats as each one is taken.
    assign load  = ar_hs || (r_state == R_DATA && r_hs && !s_axi_rlast);

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next-state logic and selection of the beat to load.
    always_comb begin
        r_next   = r_state;
        ld_addr  = rd_addr;
        ld_len   = rd_len;
        ld_size  = rd_size;
        ld_burst = rd_burst;
        ld_terr  = rd_txn_err;
        ld_cnt   = rd_cnt + 8'd1;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        if (ar_hs) begin
            ld_addr  = s_axi_araddr;
            ld_len   = s_axi_arlen;
            ld_size  = s_axi_arsize;
            ld_burst = s_axi_arburst;
            ld_terr  = txn_err(s_axi_arburst, s_axi_arlen, s_axi_arsize);
            ld_cnt   = '0;
        end
        ld_ok = !ld_terr && in_range(ld_addr);
    end

    // Registered read data path; a stalled beat simply is not reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            rd_addr <= '0; rd_len <= '0; rd_cnt <= '0; rd_size <= '0;
            rd_burst <= '0; rd_txn_err <= 1'b0;
        end else begin
            s_axi_arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                s_axi_rid  <= s_axi_arid;
                rd_len     <= s_axi_arlen;
                rd_size    <= s_axi_arsize;
                rd_burst   <= s_axi_arburst;
                rd_txn_err <= ld_terr;
            end
            if (load) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= ld_ok ? mem[word_idx(ld_addr)] : '0;
                s_axi_rresp  <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                s_axi_rlast  <= (ld_cnt == ld_len);
                rd_cnt       <= ld_cnt;
                rd_addr      <= next_addr(ld_addr, ld_size, ld_len, ld_burst);
            end else if (r_hs) begin
                s_axi_rvalid <= 1'b0;
                s_axi_rlast  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axi4_burst_ram.md
Name: axi4_burst_ram

Overview:
AXI4 slave memory that succeeds the fixed-configuration RAM DUT used with the AXI master VIP bench. It is parametrised in data width, address width, ID width and memory size. It supports FIXED, INCR and WRAP bursts, narrow transfers, ID echo, read/write backpressure and SLVERR reporting. It sits behind the VIP master or an interconnect as a scratch memory.

Parameters:
DATA_WIDTH, 32, data bus width in bits; power of 2, 8..1024
ADDR_WIDTH, 16, byte address width
ID_WIDTH, 4, AXI ID width
MEM_BYTES, 4096, memory size in bytes; power of 2, at least DATA_WIDTH/8, at most 2**ADDR_WIDTH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus 1
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  burst type
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW  read address channel
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- Reset: async assert; all outputs 0 (readies, valids, resp, last, id, rdata). Both FSMs go to IDLE. Memory contents are not cleared and are retained across reset.
- Read and write paths are independent. Each path allows one outstanding transaction. A same-cycle read and write to the same word is read-first: the read returns the old data.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, capture id/addr/len/size/burst, clear the error flag and beat counter, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb=1 into word addr>>log2(DATA_WIDTH/8), then advances the address. When beat count equals len, go to W_RESP.
  - W_RESP: bvalid=1, bid = captured id. Hold until bready, then go to W_IDLE. awready is first reasserted on the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, capture fields and go to R_DATA.
  - R_DATA: first rvalid occurs 1 cycle after the AR handshake. Memory is read synchronously into a registered output. The next beat is loaded only when !rvalid or rready, so one beat per cycle is sustained with rready held high.
  - While rvalid=1 and rready=0, rdata/rresp/rlast are held stable.
  - rlast=1 only on beat len. The R handshake of that beat returns to R_IDLE, and arready rises on the next cycle.
- Address generation (ADDR_WIDTH-wide, modulo 2**ADDR_WIDTH):
  - FIXED: address unchanged.
  - INCR: next = (addr aligned to 2**size) + 2**size; an unaligned start affects only the first beat.
  - WRAP: container = (len+1)*2**size; next = (addr & ~(container-1)) | ((addr + 2**size) & (container-1)).
- Errors (bresp/rresp SLVERR=2'b10, otherwise OKAY):
  - Whole transaction errors: burst=2'b11; WRAP with len not in {1,3,7,15}; size > log2(DATA_WIDTH/8). No memory is written, all read beats return rdata 0, and the full beat count is still transferred.
  - Per-beat error: beat address >= MEM_BYTES. A write beat is dropped and the B response is SLVERR. A read beat returns rdata 0 with SLVERR; other beats return OKAY.
  - wlast mismatch: wlast asserted on a beat other than beat len, or missing on beat len, gives SLVERR. The beat count, not wlast, terminates the burst.
- Reset mid-burst: the transaction is abandoned with no response issued. Beats already written remain in memory.

Test Plan:
1. awid=5 INCR len=2 size=4B at 0x100, data {deadbeef,c0decafe,babeb00b}, strb F -> bid=5, OKAY. Then arid=3 read at 0x100 len=2 -> same 3 words, rid=3, OKAY x3, rlast on beat 2 only.
2. WRAP len=3 size=4B read at 0x108 after writing 0x100..0x10C with 0xA0..0xA3 -> beat order A2,A3,A0,A1.
3. Write 0xFFFFFFFF at 0x200, then 0x11223344 with strb 0101 -> read 0x200 returns 0xFF22FF44. FIXED len=3 write at 0x204 with data 1,2,3,4 -> read 0x204 returns 4.
4. INCR len=1 write at MEM_BYTES-4 -> bresp SLVERR, first word written. Read the same range -> rresp OKAY then SLVERR with rdata 0. burst=2'b11 -> all beats SLVERR.
5. 4-beat read with rready pattern 1,0,1,0,1,0,1 -> exactly 4 beats, rdata stable across stalls, rlast on the 4th only. bready held low 10 cycles -> bvalid stays 1 and awready stays 0.
6. rst pulse during beat 3 of an 8-beat write -> all outputs 0 within the same cycle. After release, awready=1 and a new read of beats 0-2 returns the written data with OKAY.
